// File: rtl/complex_div_unit.sv
// rtl/complex_div_unit.sv - Iterative Q1.15 complex divider, a*conj(b)/|b|^2
// Two restoring dividers share |b|^2 and produce one quotient bit per cycle.
package fixed_point_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;
endpackage

module complex_div_unit
  import fixed_point_pkg::*;
#(
  parameter int SAT_EN = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  complex_t operand_a,
  input  complex_t operand_b,
  output logic     out_valid,
  input  logic     out_ready,
  output complex_t result,
  output logic     div_by_zero,
  output logic     overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  complex_t    r_a, r_b;
  logic [31:0] r_den;
  logic [31:0] r_rem_re, r_rem_im;
  logic [16:0] r_dvd_re, r_dvd_im;
  logic [15:0] r_q_re, r_q_im;
  logic        r_neg_re, r_neg_im, r_oor_re, r_oor_im, r_zero_den;
  logic [4:0]  r_cnt;
  complex_t    r_result;
  logic        r_dbz, r_ovf, r_out_valid;

  logic signed [15:0] w_ar, w_ai, w_br, w_bi;
  logic signed [31:0] w_p_arbr, w_p_aibi, w_p_aibr, w_p_arbi, w_p_brbr, w_p_bibi;
  logic [32:0] w_num_re, w_num_im, w_mag_re, w_mag_im;
  logic [31:0] w_den;
  logic        w_oor_re, w_oor_im;

  assign w_ar = r_a.re;
  assign w_ai = r_a.im;
  assign w_br = r_b.re;
  assign w_bi = r_b.im;

  assign w_p_arbr = w_ar * w_br;
  assign w_p_aibi = w_ai * w_bi;
  assign w_p_aibr = w_ai * w_br;
  assign w_p_arbi = w_ar * w_bi;
  assign w_p_brbr = w_br * w_br;
  assign w_p_bibi = w_bi * w_bi;

  assign w_num_re = {w_p_arbr[31], w_p_arbr} + {w_p_aibi[31], w_p_aibi};
  assign w_num_im = {w_p_aibr[31], w_p_aibr} - {w_p_arbi[31], w_p_arbi};
  assign w_mag_re = w_num_re[32] ? (~w_num_re + 33'd1) : w_num_re;
  assign w_mag_im = w_num_im[32] ? (~w_num_im + 33'd1) : w_num_im;
  assign w_den    = $unsigned(w_p_brbr) + $unsigned(w_p_bibi);
  assign w_oor_re = {1'b0, w_mag_re} >= {w_den, 2'b00};
  assign w_oor_im = {1'b0, w_mag_im} >= {w_den, 2'b00};

  // The remainder is preloaded with |num|>>2, so only the 17 low dividend bits remain to shift in.
  logic [32:0] w_trial_re, w_trial_im;
  logic        w_bit_re, w_bit_im;
  logic [31:0] w_rem_nx_re, w_rem_nx_im;
  logic [16:0] w_fin_re, w_fin_im;

  assign w_trial_re  = {r_rem_re, r_dvd_re[16]};
  assign w_trial_im  = {r_rem_im, r_dvd_im[16]};
  assign w_bit_re    = w_trial_re >= {1'b0, r_den};
  assign w_bit_im    = w_trial_im >= {1'b0, r_den};
  assign w_rem_nx_re = w_bit_re ? (w_trial_re[31:0] - r_den) : w_trial_re[31:0];
  assign w_rem_nx_im = w_bit_im ? (w_trial_im[31:0] - r_den) : w_trial_im[31:0];

  function automatic logic [16:0] f_finish(input logic [16:0] i_q, input logic i_neg,
                                           input logic i_oor);
    logic [16:0] w_sq;
    logic        w_bad;
    w_sq  = i_neg ? (~i_q + 17'd1) : i_q;
    w_bad = i_oor | (i_neg ? (i_q > 17'd32768) : (i_q > 17'd32767));
    if (w_bad && (SAT_EN != 0)) begin
      return {1'b1, (i_neg ? 16'h8000 : 16'h7FFF)};
    end
    return {w_bad, w_sq[15:0]};
  endfunction

  assign w_fin_re = f_finish({r_q_re, w_bit_re}, r_neg_re, r_oor_re);
  assign w_fin_im = f_finish({r_q_im, w_bit_im}, r_neg_im, r_oor_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_den       <= '0;
      r_rem_re    <= '0;
      r_rem_im    <= '0;
      r_dvd_re    <= '0;
      r_dvd_im    <= '0;
      r_q_re      <= '0;
      r_q_im      <= '0;
      r_neg_re    <= 1'b0;
      r_neg_im    <= 1'b0;
      r_oor_re    <= 1'b0;
      r_oor_im    <= 1'b0;
      r_zero_den  <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_rem_re   <= {1'b0, w_mag_re[32:2]};
          r_rem_im   <= {1'b0, w_mag_im[32:2]};
          r_dvd_re   <= {w_mag_re[1:0], 15'd0};
          r_dvd_im   <= {w_mag_im[1:0], 15'd0};
          r_neg_re   <= w_num_re[32];
          r_neg_im   <= w_num_im[32];
          r_oor_re   <= w_oor_re;
          r_oor_im   <= w_oor_im;
          r_den      <= w_den;
          r_zero_den <= (w_den == 32'd0);
          r_q_re     <= '0;
          r_q_im     <= '0;
          r_cnt      <= '0;
          r_state    <= S_DIV;
        end
        S_DIV: begin
          r_rem_re <= w_rem_nx_re;
          r_rem_im <= w_rem_nx_im;
          r_dvd_re <= {r_dvd_re[15:0], 1'b0};
          r_dvd_im <= {r_dvd_im[15:0], 1'b0};
          r_q_re   <= {r_q_re[14:0], w_bit_re};
          r_q_im   <= {r_q_im[14:0], w_bit_im};
          r_cnt    <= r_cnt + 5'd1;
          // A zero divisor leaves after one pass through DIV, giving a two-edge latency.
          if (r_zero_den) begin
            r_result    <= '0;
            r_dbz       <= 1'b1;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_cnt == 5'd16) begin
            r_result.re <= w_fin_re[15:0];
            r_result.im <= w_fin_im[15:0];
            r_ovf       <= w_fin_re[16] | w_fin_im[16];
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_complex_div_unit.sv
// tb/tb_complex_div_unit.sv - Scoreboard bench for complex_div_unit
module tb_complex_div_unit;
  import fixed_point_pkg::*;

  logic     clk = 1'b0;
  logic     rst, in_valid, out_ready;
  complex_t op_a, op_b, res, res_w;
  logic     in_ready, out_valid, dbz, ovf;
  logic     in_ready_w, out_valid_w, dbz_w, ovf_w;

  complex_div_unit #(.SAT_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(op_a), .operand_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(res), .div_by_zero(dbz), .overflow(ovf)
  );

  complex_div_unit #(.SAT_EN(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .operand_a(op_a), .operand_b(op_b), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(res_w), .div_by_zero(dbz_w), .overflow(ovf_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    complex_t r;
    complex_t rw;
    logic     dbz;
    logic     ovf;
    int       lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   acc    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [16:0] mdl_comp(input longint n, input longint den, input bit sat);
    longint mag, q, v;
    bit     neg, bad;
    logic [63:0] vb;
    neg = (n < 0);
    mag = neg ? -n : n;
    q   = (mag * 32768) / den;
    bad = neg ? (q > 32768) : (q > 32767);
    v   = neg ? -q : q;
    if (bad && sat) v = neg ? -32768 : 32767;
    vb = v;
    return {bad, vb[15:0]};
  endfunction

  function automatic exp_t model(input complex_t a, input complex_t b);
    exp_t   e;
    longint ar, ai, br, bi, nre, nim, den;
    logic [16:0] sr, si, wr, wi;
    ar = $signed(a.re); ai = $signed(a.im);
    br = $signed(b.re); bi = $signed(b.im);
    nre = ar * br + ai * bi;
    nim = ai * br - ar * bi;
    den = br * br + bi * bi;
    if (den == 0) begin
      e.r = '0; e.rw = '0; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 2;
    end else begin
      sr = mdl_comp(nre, den, 1'b1);
      si = mdl_comp(nim, den, 1'b1);
      wr = mdl_comp(nre, den, 1'b0);
      wi = mdl_comp(nim, den, 1'b0);
      e.r   = {sr[15:0], si[15:0]};
      e.rw  = {wr[15:0], wi[15:0]};
      e.dbz = 1'b0;
      e.ovf = sr[16] | si[16];
      e.lat = 18;
    end
    return e;
  endfunction

  function automatic bit in_range(input complex_t a, input complex_t b);
    longint ar, ai, br, bi, nre, nim, den;
    ar = $signed(a.re); ai = $signed(a.im);
    br = $signed(b.re); bi = $signed(b.im);
    nre = ar * br + ai * bi;
    nim = ai * br - ar * bi;
    den = br * br + bi * bi;
    if (nre < 0) nre = -nre;
    if (nim < 0) nim = -nim;
    return (den > 0) && (nre < 4 * den) && (nim < 4 * den);
  endfunction

  function automatic complex_t mk(input int re, input int im);
    complex_t c;
    c.re = re[15:0];
    c.im = im[15:0];
    return c;
  endfunction

  task automatic send(input complex_t a, input complex_t b);
    int n = 0;
    @(negedge clk);
    op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    acc = cyc + 1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv(input int hold);
    int       n = 0;
    int       rdy_seen = 0;
    exp_t     e;
    complex_t r0;
    logic [1:0] f0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_seen++;
      @(negedge clk);
      n++;
    end
    chk("out_timeout", out_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("latency", cyc - acc, e.lat);
      chk("busy_in_ready", rdy_seen, 0);
      chk("result", res, e.r);
      chk("div_by_zero", dbz, e.dbz);
      chk("overflow", ovf, e.ovf);
      chk("wrap_valid", out_valid_w, 1);
      chk("wrap_result", res_w, e.rw);
      chk("wrap_flags", {dbz_w, ovf_w}, {e.dbz, e.ovf});
    end
    r0 = res;
    f0 = {dbz, ovf};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", res, r0);
      chk("hold_flags", {dbz, ovf}, f0);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  int dv[9][4] = '{
    '{8192, 0, 16384, 0},
    '{8192, 8192, 16384, 16384},
    '{0, 8192, 0, 16384},
    '{-8192, 0, 16384, 0},
    '{16384, 0, 8192, 0},
    '{-16384, 0, 8192, 0},
    '{-32768, 0, -32768, 0},
    '{12345, -777, 0, 0},
    '{0, 0, 1234, -99}
  };

  initial begin
    complex_t a, b;
    exp_t     e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", res, 0);
    chk("rst_flags", {dbz, ovf}, 0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      send(mk(dv[i][0], dv[i][1]), mk(dv[i][2], dv[i][3]));
      recv(0);
    end

    // Spot checks of fixed expected values independent of the model
    send(mk(16384, 0), mk(8192, 0));
    e = sb[0];
    recv(0);
    chk("sat_pos_const", e.r, {16'h7FFF, 16'h0000});
    chk("wrap_pos_const", e.rw, 32'h0);
    send(mk(8192, 0), mk(16384, 0));
    e = sb[0];
    recv(0);
    chk("half_const", e.r, {16'h4000, 16'h0000});

    // Random in-range vectors
    for (int i = 0; i < 16; i++) begin
      int tries = 0;
      do begin
        a = complex_t'($urandom);
        b = complex_t'($urandom);
        tries++;
      end while (!in_range(a, b) && tries < 1000);
      send(a, b);
      recv(0);
    end

    // Backpressure with a competing input held during DONE
    send(mk(-8192, 4096), mk(16384, -2048));
    op_a = mk(3000, -4000); op_b = mk(20000, 100);
    in_valid = 1'b1;
    recv(5);
    chk("second_ready", in_ready & in_valid, 1);
    acc = cyc + 1;
    sb.push_back(model(op_a, op_b));
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv(0);

    // Reset while dividing
    send(mk(8192, 8192), mk(16384, 0));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", res, 0);
    chk("midrst_flags", {dbz, ovf}, 0);
    void'(sb.pop_back());
    send(mk(-4096, 12000), mk(-16000, 9000));
    recv(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
